// File: rtl/handshake_upsizer.sv
// ---------------------------------------------------------------------------
// handshake_upsizer
//
// Packs RATIO consecutive narrow input beats into one wide output word.
// Lanes fill little-endian: the first beat of a word lands in the lowest
// IN_BITS of m_data. A beat with s_last set closes the word early. Lanes that
// were never written read as zero and have their m_keep bit cleared.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready. A producer never drops valid or changes its payload
// until the transfer happens. Ready may depend combinationally on the other
// side's ready, never on this side's own valid.
//
// Ports:
//   clk      in   clock, all logic on posedge
//   rst      in   asynchronous reset, active low (0 = in reset)
//   s_valid  in   input beat valid
//   s_ready  out  input beat ready (low during reset and while a word stalls)
//   s_data   in   input beat payload, IN_BITS wide
//   s_last   in   last beat of a packet, closes the current word
//   m_valid  out  output word valid
//   m_ready  in   output word ready
//   m_data   out  packed output word, IN_BITS*RATIO wide
//   m_keep   out  per-lane valid flags, RATIO wide
//   m_last   out  output word ends a packet
// ---------------------------------------------------------------------------
module handshake_upsizer #(
  parameter  int IN_BITS  = 8,
  parameter  int RATIO    = 4,
  localparam int OUT_BITS = IN_BITS * RATIO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_BITS-1:0]  s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  output logic [RATIO-1:0]    m_keep,
  output logic                m_last
);

  // Lane counter width. The guard keeps the declaration legal long enough for
  // the RATIO check below to report a readable message.
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("handshake_upsizer: RATIO must be 2 or more");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    r_cnt;      // lane the next accepted beat lands in
  logic [OUT_BITS-1:0] r_acc;      // partial word, unwritten lanes held at 0
  logic                r_m_valid;
  logic [OUT_BITS-1:0] r_m_data;
  logic [RATIO-1:0]    r_m_keep;
  logic                r_m_last;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_last_lane;
  logic                w_complete;
  logic [OUT_BITS-1:0] w_acc_merged;
  logic [RATIO-1:0]    w_keep_merged;

  // Input is taken whenever the output register is empty or being emptied
  // this cycle, so a completing beat can overwrite a word leaving on the same
  // edge. Gating with rst keeps the source stalled throughout reset.
  assign s_ready     = rst && (!r_m_valid || m_ready);
  assign w_in_xfer   = s_valid && s_ready;
  assign w_out_xfer  = r_m_valid && m_ready;
  assign w_last_lane = (r_cnt == LAST_LANE);
  assign w_complete  = w_in_xfer && (w_last_lane || s_last);

  // Accumulator with the incoming beat dropped into lane r_cnt. Keep flags
  // are not stored: lanes 0..r_cnt are exactly the ones written so far.
  always_comb begin
    w_acc_merged  = r_acc;
    w_keep_merged = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == r_cnt) begin
        w_acc_merged[k*IN_BITS +: IN_BITS] = s_data;
      end
      w_keep_merged[k] = (CNT_W'(k) <= r_cnt);
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator and lane counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_in_xfer) begin
      if (w_complete) begin
        // Clearing here is what makes unwritten lanes of a short word zero.
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        // w_complete covers the last lane, so this never runs past RATIO-1.
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_acc_merged;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_complete) begin
      // s_ready guarantees the register is empty or draining this edge.
      r_m_valid <= 1'b1;
      r_m_data  <= w_acc_merged;
      r_m_keep  <= w_keep_merged;
      r_m_last  <= s_last;
    end else if (w_out_xfer) begin
      // Payload is left stale; it is don't-care while m_valid is low.
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_keep  = r_m_keep;
  assign m_last  = r_m_last;

endmodule

// File: tb/tb_handshake_upsizer.sv
// ---------------------------------------------------------------------------
// tb_handshake_upsizer
//
// Drives byte beats into handshake_upsizer (IN_BITS=8, RATIO=4) and compares
// every output word against a packet-level model: collected bytes are packed
// into a word with shifts once four are gathered or s_last is seen.
// ---------------------------------------------------------------------------
module tb_handshake_upsizer;

  localparam int IN_BITS  = 8;
  localparam int RATIO    = 4;
  localparam int OUT_BITS = IN_BITS * RATIO;
  localparam int W        = 1 + RATIO + OUT_BITS;  // {last, keep, data}

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [IN_BITS-1:0]  s_data;
  logic                s_last;
  logic                m_valid;
  logic                m_ready;
  logic [OUT_BITS-1:0] m_data;
  logic [RATIO-1:0]    m_keep;
  logic                m_last;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  handshake_upsizer #(.IN_BITS(IN_BITS), .RATIO(RATIO)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model and scoreboard
  // -------------------------------------------------------------------------
  logic [IN_BITS-1:0] cur[$];     // bytes of the word being collected
  logic [W-1:0]       exp_q[$];   // words the DUT owes, oldest first
  logic [W-1:0]       obs_log[$]; // words actually accepted downstream

  function automatic logic [W-1:0] pack_word(input logic is_last);
    logic [OUT_BITS-1:0] d = '0;
    logic [RATIO-1:0]    k;
    int                  n = cur.size();
    for (int i = 0; i < n; i++) d = d | (OUT_BITS'(cur[i]) << (IN_BITS * i));
    k = RATIO'((1 << n) - 1);
    return {is_last, k, d};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data",  64'(m_data),  64'(0));
      chk("rst_m_keep",  64'(m_keep),  64'(0));
      chk("rst_m_last",  64'(m_last),  64'(0));
      chk("rst_s_ready", 64'(s_ready), 64'(0));
      cur.delete();
      exp_q.delete();
    end else begin
      chk("s_ready", 64'(s_ready), 64'((exp_q.size() == 0) || m_ready));
      chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && m_valid) begin
        chk("m_data", 64'(m_data), 64'(exp_q[0][OUT_BITS-1:0]));
        chk("m_keep", 64'(m_keep), 64'(exp_q[0][OUT_BITS +: RATIO]));
        chk("m_last", 64'(m_last), 64'(exp_q[0][W-1]));
        if (m_ready) begin
          obs_log.push_back({m_last, m_keep, m_data});
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        cur.push_back(s_data);
        if (cur.size() == RATIO || s_last) begin
          exp_q.push_back(pack_word(s_last));
          cur.delete();
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  bit rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [IN_BITS-1:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("accept_timeout", 64'(waited), 64'(0));
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_word(input string tag, input int idx, input logic [W-1:0] e);
    logic [W-1:0] o = 'x;
    if (idx < obs_log.size()) o = obs_log[idx];
    chk(tag, 64'(o), 64'(e));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int t0;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);

    // 1: full word, always-ready sink
    m_ready = 1'b1;
    obs_log.delete();
    send_beat(8'hA5, 0); send_beat(8'hC4, 0); send_beat(8'h11, 0); send_beat(8'h22, 0);
    idle(3);
    chk("t1_count", 64'(obs_log.size()), 64'(1));
    check_word("t1_word", 0, {1'b0, 4'hF, 32'h2211C4A5});

    // 2: early s_last then a full word
    obs_log.delete();
    send_beat(8'hA5, 0); send_beat(8'hC4, 1);
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
    idle(3);
    chk("t2_count", 64'(obs_log.size()), 64'(2));
    check_word("t2_word0", 0, {1'b1, 4'h3, 32'h0000C4A5});
    check_word("t2_word1", 1, {1'b0, 4'hF, 32'h04030201});

    // 3: backpressure holds the word and stalls a new beat
    m_ready = 1'b0;
    obs_log.delete();
    send_beat(8'hE0, 0); send_beat(8'hE1, 0); send_beat(8'hE2, 0); send_beat(8'hE3, 0);
    fork
      send_beat(8'h5A, 0);
      begin idle(5); m_ready = 1'b1; end
    join
    send_beat(8'h5B, 0); send_beat(8'h5C, 0); send_beat(8'h5D, 0);
    idle(3);
    chk("t3_count", 64'(obs_log.size()), 64'(2));
    check_word("t3_word0", 0, {1'b0, 4'hF, 32'hE3E2E1E0});
    check_word("t3_word1", 1, {1'b0, 4'hF, 32'h5D5C5B5A});

    // 4: streaming, one beat per cycle
    obs_log.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_beat(8'(i), 0);
    chk("t4_cycles", 64'(cyc - t0), 64'(8));
    idle(3);
    chk("t4_count", 64'(obs_log.size()), 64'(2));
    check_word("t4_word0", 0, {1'b0, 4'hF, 32'h03020100});
    check_word("t4_word1", 1, {1'b0, 4'hF, 32'h07060504});

    // 5: s_last on the final lane gives no trailing empty word
    obs_log.delete();
    send_beat(8'hAA, 0); send_beat(8'hBB, 0); send_beat(8'hCC, 0); send_beat(8'hDD, 1);
    idle(4);
    chk("t5_count", 64'(obs_log.size()), 64'(1));
    check_word("t5_word", 0, {1'b1, 4'hF, 32'hDDCCBBAA});

    // 6: reset mid-word discards the partial word
    obs_log.delete();
    send_beat(8'h77, 0); send_beat(8'h88, 0);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);
    send_beat(8'h10, 0); send_beat(8'h20, 0); send_beat(8'h30, 0); send_beat(8'h40, 0);
    idle(3);
    chk("t6_count", 64'(obs_log.size()), 64'(1));
    check_word("t6_word", 0, {1'b0, 4'hF, 32'h40302010});

    // Random traffic with random gaps, packet ends and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
      send_beat(8'($urandom), ($urandom_range(0, 4) == 0));
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    send_beat(8'hFF, 1);
    idle(4);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/handshake_upsizer.md
Name: handshake_upsizer

Overview:
- Valid/ready width converter that packs RATIO consecutive narrow input beats into one wide output beat.
- Sits downstream of handshake_master and upstream of handshake_slave; for example, it packs 8-bit byte streams into 32-bit words.
- Input s_last flushes a partial word early; m_keep marks which lanes of the output word are valid.

Parameters:
- IN_BITS, 8: width of one input beat.
- RATIO, 4: input beats per output word. Must be 2 or more; an elaboration-time check rejects smaller values.
- OUT_BITS, IN_BITS*RATIO: derived output width. Not overridable.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  asynchronous, active-low reset. 0 = in reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  IN_BITS  input beat data.
- s_last  in  1  final beat of a packet; closes the current word.
- m_valid  out  1  output word valid.
- m_ready  in  1  output word ready.
- m_data  out  OUT_BITS  packed output word.
- m_keep  out  RATIO  per-lane valid flags.
- m_last  out  1  output word ends a packet.

Behaviour:
- Transfers:
  - An input transfer occurs on a posedge with s_valid && s_ready.
  - An output transfer occurs on a posedge with m_valid && m_ready.
- Reset state (rst low, applied asynchronously):
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - Lane counter cnt=0; accumulator cleared.
  - s_ready forced to 0 for as long as rst is low.
- Lane order is little-endian. The beat accepted with cnt=k lands in bits [k*IN_BITS +: IN_BITS] of the accumulator and sets keep bit k.
- cnt is a clog2(RATIO)-bit counter with range 0..RATIO-1:
  - Increments on each input transfer.
  - Returns to 0 when a word completes.
  - Never wraps silently past RATIO-1.
- A word completes on the input transfer where cnt==RATIO-1 or s_last==1, whichever happens first. On that posedge:
  - The accumulator plus the completing beat load into the output register.
  - m_keep is loaded; m_last=s_last; m_valid=1.
  - Lanes never written are 0 in m_data and 0 in m_keep.
  - Accumulator and cnt clear, so the next beat goes to lane 0.
- Latency: m_valid rises exactly one cycle after the completing input transfer.
- s_ready = rst && (!m_valid || m_ready). This is combinational from m_ready, with no combinational path from s_valid.
  - While a word is held unaccepted, input stalls, including partial-word beats.
  - With m_ready held at 1, throughput is one input beat per cycle with no bubbles.
- Output holding: m_valid, m_data, m_keep and m_last stay stable while m_valid && !m_ready. m_valid never drops without an output transfer.
- Output drain: after an output transfer with no word completing the same cycle, m_valid goes to 0 next cycle. m_data and m_keep may hold stale values and are don't-care while m_valid=0.
- Simultaneous output transfer and word completion: the new word replaces the old one and m_valid stays 1.
- Gaps: s_valid low for any number of cycles mid-word leaves the accumulator and cnt unchanged.
- s_last on the beat where cnt==RATIO-1: a single full word with m_keep all ones and m_last=1. No extra empty word is produced.
- Reset mid-operation: any partial or held word is discarded. After rst rises, the next beat goes to lane 0.

Test Plan:
1. Always-ready sink, beats A5, C4, 11, 22 with no s_last -> one word: m_data=0x2211C4A5, m_keep=0xF, m_last=0. m_valid is high the cycle after the 4th beat, for exactly 1 cycle.
2. Beats A5, C4 with s_last on C4, then 01, 02, 03, 04 -> first word m_data=0x0000C4A5, m_keep=0x3, m_last=1. Second word m_data=0x04030201, m_keep=0xF, m_last=0.
3. Backpressure: complete a word, hold m_ready=0 for 5 cycles while s_valid=1 -> m_data/m_keep/m_valid stable, s_ready=0, no beats consumed. Then release -> the word is accepted and input resumes at lane 0 with no data loss.
4. Streaming: 8 consecutive beats 00..07 with s_valid=1 and m_ready=1 -> s_ready stays high throughout. Words 0x03020100 and 0x07060504 appear on consecutive 4-cycle boundaries.
5. s_last on the 4th beat (AA, BB, CC, DD) -> one word 0xDDCCBBAA, m_keep=0xF, m_last=1, and no trailing empty word.
6. Reset mid-word: accept 2 beats, pull rst low for 3 cycles -> all outputs 0 and s_ready=0 during reset. After release, beats 10, 20, 30, 40 -> m_data=0x40302010, m_keep=0xF.
